// File: rtl/display_sched_pkg.sv
// Shared definitions for the display scheduler: FSM state encoding, default
// timing parameters and the display word width.
package display_sched_pkg;

  localparam int DISP_W        = 16;
  localparam int DEF_DWELL     = 50_000_000;
  localparam int DEF_DEB       = 500_000;
  localparam int DEF_ALERT_LEN = 100_000_000;

  typedef enum logic {
    SHOW  = 1'b0,
    ALERT = 1'b1
  } state_e;

endpackage

// File: rtl/display_sched_btn_debounce.sv
// Push-button front end: 2-flop synchroniser, DEB-sample stability filter and
// a one-cycle pulse on each debounced press (release gives no pulse).
module btn_debounce
  import display_sched_pkg::*;
#(
  parameter int DEB = DEF_DEB
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser into one stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // DEB consecutive differing samples: accept the new level
        stable <= sync2;
        cnt    <= '0;
        pulse  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_sched.sv
// Chooses the 16-bit word shown on the hex display: rotating/stepped debug
// sources, preempted by a timed alert slot granted through req/ack.
module display_sched
  import display_sched_pkg::*;
#(
  parameter int NSRC      = 4,
  parameter int DWELL     = DEF_DWELL,
  parameter int DEB       = DEF_DEB,
  parameter int ALERT_LEN = DEF_ALERT_LEN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NSRC*DISP_W-1:0]   src_data,
  input  logic                     mode_auto,
  input  logic                     btn_next,
  input  logic                     alert_req,
  input  logic [DISP_W-1:0]        alert_data,
  output logic                     alert_ack,
  output logic [DISP_W-1:0]        num,
  output logic [$clog2(NSRC)-1:0]  src_idx,
  output logic                     in_alert
);

  localparam int IW = $clog2(NSRC);
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int AW = (ALERT_LEN > 1) ? $clog2(ALERT_LEN) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [AW-1:0] ALERT_LAST = AW'(ALERT_LEN - 1);

  state_e              state, state_nx;
  logic [DW-1:0]       dwell_cnt, dwell_nx;
  logic [AW-1:0]       alert_cnt, acnt_nx;
  logic [DISP_W-1:0]   alert_lat, lat_nx;
  logic [DISP_W-1:0]   num_nx;
  logic [IW-1:0]       idx_nx;
  logic                ack_nx;
  logic                btn_pulse;
  logic [DISP_W-1:0]   src_arr [NSRC];

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    assign src_arr[k] = src_data[k*DISP_W +: DISP_W];
  end

  btn_debounce #(.DEB(DEB)) u_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_next),
    .pulse   (btn_pulse)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= SHOW;
    else        state <= state_nx;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      SHOW:    if (alert_req)                state_nx = ALERT;
      ALERT:   if (alert_cnt == ALERT_LAST)  state_nx = SHOW;
      default: state_nx = SHOW;
    endcase
  end

  always_comb begin
    idx_nx   = src_idx;
    dwell_nx = dwell_cnt;
    acnt_nx  = alert_cnt;
    lat_nx   = alert_lat;
    ack_nx   = 1'b0;
    num_nx   = src_arr[src_idx];
    case (state)
      SHOW: begin
        if (alert_req) begin
          // Alert preempts a coincident button pulse or dwell expiry
          ack_nx   = 1'b1;
          lat_nx   = alert_data;
          num_nx   = alert_data;
          acnt_nx  = '0;
          dwell_nx = '0;
        end else if (btn_pulse) begin
          idx_nx   = src_idx + 1'b1;
          dwell_nx = '0;
        end else if (mode_auto) begin
          if (dwell_cnt == DWELL_LAST) begin
            idx_nx   = src_idx + 1'b1;
            dwell_nx = '0;
          end else begin
            dwell_nx = dwell_cnt + 1'b1;
          end
        end else begin
          dwell_nx = '0;
        end
      end
      ALERT: begin
        dwell_nx = '0;
        num_nx   = alert_lat;
        if (alert_cnt == ALERT_LAST) begin
          acnt_nx = '0;
          num_nx  = src_arr[src_idx];
        end else begin
          acnt_nx = alert_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_idx   <= '0;
      dwell_cnt <= '0;
      alert_cnt <= '0;
      alert_lat <= '0;
      alert_ack <= 1'b0;
      num       <= '0;
    end else begin
      src_idx   <= idx_nx;
      dwell_cnt <= dwell_nx;
      alert_cnt <= acnt_nx;
      alert_lat <= lat_nx;
      alert_ack <= ack_nx;
      num       <= num_nx;
    end
  end

  assign in_alert = (state == ALERT);

endmodule

// File: tb/tb_display_sched.sv
// Directed bench for display_sched with short sim timing
// (NSRC=4, DWELL=8, DEB=4, ALERT_LEN=6).
module tb_display_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] src_data;
  logic        mode_auto;
  logic        btn_next;
  logic        alert_req;
  logic [15:0] alert_data;
  logic        alert_ack;
  logic [15:0] num;
  logic [1:0]  src_idx;
  logic        in_alert;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  display_sched #(.NSRC(4), .DWELL(8), .DEB(4), .ALERT_LEN(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_data   (src_data),
    .mode_auto  (mode_auto),
    .btn_next   (btn_next),
    .alert_req  (alert_req),
    .alert_data (alert_data),
    .alert_ack  (alert_ack),
    .num        (num),
    .src_idx    (src_idx),
    .in_alert   (in_alert)
  );

  typedef struct {
    string       name;
    logic        auto_m;
    int          cycles;
    logic [1:0]  idx;
    logic [15:0] num;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1 time unit after.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input logic [1:0] idx, input logic [15:0] n,
                           input logic ack, input logic ia);
    check({name, ".src_idx"}, {14'd0, src_idx}, {14'd0, idx});
    check({name, ".num"}, num, n);
    check({name, ".ack"}, {15'd0, alert_ack}, {15'd0, ack});
    check({name, ".in_alert"}, {15'd0, in_alert}, {15'd0, ia});
  endtask

  task automatic press(input int hold);
    btn_next = 1'b1;
    step(hold);
    btn_next = 1'b0;
  endtask

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{"auto_d7",   1'b1, 7,  2'd0, 16'h1111};
    tbl[1]  = '{"auto_adv1", 1'b1, 1,  2'd1, 16'h1111};
    tbl[2]  = '{"auto_lag1", 1'b1, 1,  2'd1, 16'h2222};
    tbl[3]  = '{"auto_hold1",1'b1, 6,  2'd1, 16'h2222};
    tbl[4]  = '{"auto_adv2", 1'b1, 1,  2'd2, 16'h2222};
    tbl[5]  = '{"auto_lag2", 1'b1, 1,  2'd2, 16'h3333};
    tbl[6]  = '{"auto_adv3", 1'b1, 7,  2'd3, 16'h3333};
    tbl[7]  = '{"auto_lag3", 1'b1, 1,  2'd3, 16'h4444};
    tbl[8]  = '{"auto_wrap", 1'b1, 7,  2'd0, 16'h4444};
    tbl[9]  = '{"auto_lag0", 1'b1, 1,  2'd0, 16'h1111};
    tbl[10] = '{"manual",    1'b0, 20, 2'd0, 16'h1111};

    src_data   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    rst_n      = 1'b0;
    mode_auto  = 1'b0;
    btn_next   = 1'b0;
    alert_req  = 1'b0;
    alert_data = 16'h0000;

    // Reset state, then first value one cycle after release
    step(3);
    check_all("reset", 2'd0, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1);
    check_all("release", 2'd0, 16'h1111, 1'b0, 1'b0);

    // Auto rotation and manual hold
    for (int i = 0; i < 11; i++) begin
      mode_auto = tbl[i].auto_m;
      step(tbl[i].cycles);
      check_all(tbl[i].name, tbl[i].idx, tbl[i].num, 1'b0, 1'b0);
    end

    // Button: short bounce ignored, long press advances once, release does not
    press(3);
    step(10);
    check("btn_bounce", {14'd0, src_idx}, 16'd0);
    press(10);
    step(10);
    check("btn_press", {14'd0, src_idx}, 16'd1);
    step(10);
    check("btn_release", {14'd0, src_idx}, 16'd1);
    press(10);
    step(10);
    check("btn_press2", {14'd0, src_idx}, 16'd2);

    // Alert at src_idx=2, switching to auto at the same time
    mode_auto  = 1'b1;
    alert_req  = 1'b1;
    alert_data = 16'hBEEF;
    step(1);
    check_all("alert_grant", 2'd2, 16'hBEEF, 1'b1, 1'b1);
    alert_req  = 1'b0;
    alert_data = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check_all($sformatf("alert_hold%0d", i), 2'd2, 16'hBEEF, 1'b0, 1'b1);
    end
    step(1);
    check_all("alert_exit", 2'd2, 16'h3333, 1'b0, 1'b0);
    step(7);
    check("post_dwell7", {14'd0, src_idx}, 16'd2);
    step(1);
    check("post_dwell8", {14'd0, src_idx}, 16'd3);

    // Request coincident with dwell expiry: no advance
    step(7);
    alert_req  = 1'b1;
    alert_data = 16'hCAFE;
    step(1);
    check_all("coinc_grant", 2'd3, 16'hCAFE, 1'b1, 1'b1);
    alert_req = 1'b0;
    step(1);
    alert_req  = 1'b1;
    alert_data = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check_all($sformatf("pend_hold%0d", i), 2'd3, 16'hCAFE, 1'b0, 1'b1);
    end
    step(1);
    check_all("pend_show", 2'd3, 16'h4444, 1'b0, 1'b0);
    step(1);
    check_all("pend_grant", 2'd3, 16'h1234, 1'b1, 1'b1);

    // Reset at cycle 3 of the alert with a request still pending
    step(2);
    rst_n = 1'b0;
    step(1);
    check_all("mid_rst", 2'd0, 16'h0000, 1'b0, 1'b0);
    step(1);
    check_all("mid_rst_hold", 2'd0, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1);
    check_all("rst_regrant", 2'd0, 16'h1234, 1'b1, 1'b1);
    alert_req = 1'b0;
    step(1);
    check("rst_ack_drop", {15'd0, alert_ack}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
